// File: rtl/serial_parity_gen.sv
// serial_parity_gen: serial XOR parity generator with valid/ready handshake on both sides.
// Optional macro PARITY_CHECK_EN: frame gains a received parity bit, which is checked and reported on out_err.
module serial_parity_gen #(
  parameter int FRAME_LEN  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_parity,
  output logic [15:0] frame_cnt
`ifdef PARITY_CHECK_EN
  ,
  output logic        out_err
`endif
);
  localparam int CW = $clog2(FRAME_LEN + 1);
`ifdef PARITY_CHECK_EN
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN);
`else
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
`endif
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t r_state, w_next;
  logic          r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;
  logic          r_out_parity;
  logic [15:0]   r_frame_cnt;
  logic          w_accept;
  logic          w_last;
  logic          w_deliver;
  assign w_accept  = in_valid && r_state == ACCUM;
  assign w_last    = w_accept && r_cnt == LAST;
  assign w_deliver = r_out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ACCUM;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == ACCUM) w_next = w_last ? HOLD : ACCUM;
    else                  w_next = w_deliver ? ACCUM : HOLD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= ODD_PARITY;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_parity <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      if (w_last) begin
        r_acc       <= ODD_PARITY;
        r_cnt       <= '0;
        r_out_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
        r_out_parity <= r_acc;
`else
        r_out_parity <= r_acc ^ in_bit;
`endif
      end else if (w_accept) begin
        r_acc <= r_acc ^ in_bit;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_deliver) begin
        r_out_valid <= 1'b0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end
`ifdef PARITY_CHECK_EN
  // the last bit is the sender's parity; compare it against the accumulated one
  logic r_out_err;
  always_ff @(posedge clk or posedge rst)
    if (rst)         r_out_err <= 1'b0;
    else if (w_last) r_out_err <= r_acc != in_bit;
  assign out_err = r_out_err;
`endif
  assign in_ready   = r_state == ACCUM;
  assign out_valid  = r_out_valid;
  assign out_parity = r_out_parity;
  assign frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_serial_parity_gen.sv
// tb_serial_parity_gen: scoreboard bench for serial_parity_gen (even instance plus an odd-parity instance).
module tb_serial_parity_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_parity;
  logic [15:0] frame_cnt;
  logic o_in_valid = 1'b0, o_in_bit = 1'b0, o_out_ready = 1'b0;
  logic o_in_ready, o_out_valid, o_out_parity;
  logic [15:0] o_frame_cnt;
`ifdef PARITY_CHECK_EN
  logic out_err, o_out_err;
`endif
  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  logic [1:0] sb_e;

  serial_parity_gen #(.FRAME_LEN(8), .ODD_PARITY(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity), .frame_cnt(frame_cnt)
`ifdef PARITY_CHECK_EN
    , .out_err(out_err)
`endif
  );

  serial_parity_gen #(.FRAME_LEN(8), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready), .in_bit(o_in_bit),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_parity(o_out_parity), .frame_cnt(o_frame_cnt)
`ifdef PARITY_CHECK_EN
    , .out_err(o_out_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [8:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!in_ready && t < 50) begin
        step;
        t++;
      end
      if (!in_ready) chk("ready_timeout", in_ready, 1);
      in_valid = 1'b1;
      in_bit   = bits[i];
      step;
      in_valid = 1'b0;
      if (i < n - 1) repeat (gap) step;
    end
  endtask

  // flip=1 sends a wrong received parity bit when the check is built in
  task automatic send_frame(input logic [7:0] d, input int gap, input bit flip, input bit push);
    logic p;
    p = ^d;
    if (push) exp_q.push_back({flip, p});
`ifdef PARITY_CHECK_EN
    send_bits({p ^ flip, d}, 9, gap);
`else
    send_bits({1'b0, d}, 8, gap);
`endif
  endtask

  task automatic o_send(input logic [7:0] d);
    logic [8:0] b;
    b = {~^d, d};
`ifdef PARITY_CHECK_EN
    for (int i = 0; i < 9; i++) begin
`else
    for (int i = 0; i < 8; i++) begin
`endif
      o_in_valid = 1'b1;
      o_in_bit   = b[i];
      step;
    end
    o_in_valid = 1'b0;
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_extra", 1, 0);
      else begin
        sb_e = exp_q.pop_front();
        chk("sb_par", out_parity, sb_e[0]);
`ifdef PARITY_CHECK_EN
        chk("sb_err", out_err, sb_e[1]);
`endif
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1; o_in_valid = 1'b1;
    repeat (3) step;
    chk("rst_valid", out_valid, 0);
    chk("rst_par", out_parity, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_ready", in_ready, 1);
    in_valid = 1'b0; o_in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    repeat (2) step;
    chk("idle_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);
    chk("idle_cnt", frame_cnt, 0);
    send_frame(8'b0000_1101, 0, 1'b0, 1'b1);
    chk("f1_valid", out_valid, 1);
    chk("f1_par", out_parity, 1);
    chk("f1_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_bit   = 1'b1;
      step;
      chk("hold_valid", out_valid, 1);
      chk("hold_par", out_parity, 1);
      chk("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step;
    chk("f1_consumed", out_valid, 0);
    chk("f1_cnt", frame_cnt, 1);
    send_frame(8'hFF, 2, 1'b0, 1'b1);
    chk("f2_valid", out_valid, 1);
    chk("f2_par", out_parity, 0);
    step;
    chk("f2_consumed", out_valid, 0);
    chk("f2_cnt", frame_cnt, 2);
    send_bits(9'b0_0000_0111, 4, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", frame_cnt, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    step;
    rst = 1'b0;
    step;
    send_frame(8'b0000_0001, 0, 1'b0, 1'b1);
    chk("f3_valid", out_valid, 1);
    chk("f3_par", out_parity, 1);
    step;
    chk("f3_cnt", frame_cnt, 1);
    out_ready = 1'b0;
    send_frame(8'h03, 0, 1'b0, 1'b0);
    chk("hrst_pre", out_valid, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
    chk("hrst_valid", out_valid, 0);
    chk("hrst_cnt", frame_cnt, 0);
    o_out_ready = 1'b0;
    o_send(8'h00);
    chk("odd0_valid", o_out_valid, 1);
    chk("odd0_par", o_out_parity, 1);
    o_out_ready = 1'b1;
    step;
    chk("odd0_consumed", o_out_valid, 0);
    chk("odd0_cnt", o_frame_cnt, 1);
    o_send(8'h01);
    chk("odd1_valid", o_out_valid, 1);
    chk("odd1_par", o_out_parity, 0);
    step;
`ifdef PARITY_CHECK_EN
    out_ready = 1'b1;
    send_frame(8'b0000_0011, 0, 1'b1, 1'b1);
    chk("err1", out_err, 1);
    step;
    send_frame(8'b0000_0011, 0, 1'b0, 1'b1);
    chk("err0", out_err, 0);
    step;
`endif
    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
